// File: rtl/m1_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// m1_muldiv_pkg
//   Shared definitions for the HI/LO sequencer: the execute-stage HI/LO op
//   codes and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package m1_muldiv_pkg;

  localparam logic [2:0] HILO_OP_NONE = 3'd0;
  localparam logic [2:0] HILO_OP_MULT = 3'd1;
  localparam logic [2:0] HILO_OP_DIV  = 3'd2;
  localparam logic [2:0] HILO_OP_MFHI = 3'd3;
  localparam logic [2:0] HILO_OP_MFLO = 3'd4;
  localparam logic [2:0] HILO_OP_MTHI = 3'd5;
  localparam logic [2:0] HILO_OP_MTLO = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DIVZ     = 2'd3
  } hilo_state_e;

endpackage

// File: rtl/m1_muldiv_ctrl_abp_master.sv
// ---------------------------------------------------------------------------
// abp_master
//   Two-phase (level toggle) request side of an ABP handshake. A start pulse
//   flips the request level; the transfer is complete when the slave's ack
//   level has caught up with the request level.
// Ports
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, request level returns to 0
//   start_i : one-cycle pulse, issue a new request
//   ack_i   : ack level from the slave
//   req_o   : request level to the slave
//   done_o  : ack level equals request level (no transfer outstanding)
// ---------------------------------------------------------------------------
module abp_master (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic ack_i,
  output logic req_o,
  output logic done_o
);

  logic req_d, req_q;

  always_comb begin
    req_d = req_q ^ start_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_o  = req_q;
  assign done_o = (ack_i == req_q);

endmodule

// File: rtl/m1_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// m1_muldiv_ctrl
//   Sequencer between the execute stage and the multiplier/divider. Decodes
//   MULT/DIV/MFHI/MFLO/MTHI/MTLO, issues ABP requests to the arithmetic units,
//   owns the architectural HI/LO registers and stalls any HI/LO op while a
//   multiply or divide is in flight.
// Ports
//   sys_clock_i, sys_reset_i        : clock, asynchronous active-low reset
//   op_valid_i, op_i, signed_i      : request from execute stage
//   rs_i, rt_i                      : operands (rs_i is MTHI/MTLO data)
//   stall_o                         : op not accepted this cycle
//   rdata_o                         : HI for MFHI, LO for MFLO (combinational)
//   hi_o, lo_o                      : current HI/LO
//   mul_a_o, mul_b_o, mul_signed_o  : latched multiplier operands
//   mul_req_o / mul_ack_i           : multiplier ABP levels
//   mul_product_i                   : 64-bit product
//   div_a_o, div_b_o, div_signed_o  : latched divider operands
//   div_req_o / div_ack_i           : divider ABP levels
//   div_quotient_i, div_remainder_i : divider results
// ---------------------------------------------------------------------------
module m1_muldiv_ctrl
  import m1_muldiv_pkg::*;
(
  input  logic        sys_clock_i,
  input  logic        sys_reset_i,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic        signed_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_signed_o,
  output logic        mul_req_o,
  input  logic        mul_ack_i,
  input  logic [63:0] mul_product_i,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_signed_o,
  output logic        div_req_o,
  input  logic        div_ack_i,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i
);

  hilo_state_e state_d, state_q;
  logic [31:0] hi_d, hi_q, lo_d, lo_q;
  logic [31:0] mul_a_d, mul_a_q, mul_b_d, mul_b_q;
  logic [31:0] div_a_d, div_a_q, div_b_d, div_b_q;
  logic        mul_sgn_d, mul_sgn_q, div_sgn_d, div_sgn_q;
  logic [31:0] dz_hi_d, dz_hi_q;
  logic        mul_start, div_start, mul_done, div_done;
  logic        stall, accept;

  abp_master u_mul_abp (
    .clk_i   (sys_clock_i),
    .rst_ni  (sys_reset_i),
    .start_i (mul_start),
    .ack_i   (mul_ack_i),
    .req_o   (mul_req_o),
    .done_o  (mul_done)
  );

  abp_master u_div_abp (
    .clk_i   (sys_clock_i),
    .rst_ni  (sys_reset_i),
    .start_i (div_start),
    .ack_i   (div_ack_i),
    .req_o   (div_req_o),
    .done_o  (div_done)
  );

  // Any real op stalls outside IDLE, including on the completion cycle, so a
  // follow-on HI/LO access always observes the freshly written result.
  assign stall  = op_valid_i & (op_i != HILO_OP_NONE) & (state_q != ST_IDLE);
  assign accept = op_valid_i & ~stall;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_sgn_d = mul_sgn_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    div_sgn_d = div_sgn_q;
    dz_hi_d   = dz_hi_q;
    mul_start = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ack/req disagreement here is a slave protocol error; it is simply
        // not looked at, so it can never reach HI/LO.
        if (accept) begin
          case (op_i)
            HILO_OP_MULT: begin
              mul_a_d   = rs_i;
              mul_b_d   = rt_i;
              mul_sgn_d = signed_i;
              mul_start = 1'b1;
              state_d   = ST_MUL_WAIT;
            end
            HILO_OP_DIV: begin
              if (rt_i != 32'd0) begin
                div_a_d   = rs_i;
                div_b_d   = rt_i;
                div_sgn_d = signed_i;
                div_start = 1'b1;
                state_d   = ST_DIV_WAIT;
              end else begin
                // Divide by zero never reaches the divider; the fixed
                // result is produced locally one cycle later.
                dz_hi_d = rs_i;
                state_d = ST_DIVZ;
              end
            end
            HILO_OP_MTHI: hi_d = rs_i;
            HILO_OP_MTLO: lo_d = rs_i;
            default: ;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        if (mul_done) begin
          hi_d    = mul_product_i[63:32];
          lo_d    = mul_product_i[31:0];
          state_d = ST_IDLE;
        end
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          hi_d    = div_remainder_i;
          lo_d    = div_quotient_i;
          state_d = ST_IDLE;
        end
      end
      ST_DIVZ: begin
        hi_d    = dz_hi_q;
        lo_d    = 32'hFFFF_FFFF;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
    if (!sys_reset_i) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sgn_q <= 1'b0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      div_sgn_q <= 1'b0;
      dz_hi_q   <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_sgn_q <= mul_sgn_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      div_sgn_q <= div_sgn_d;
      dz_hi_q   <= dz_hi_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (op_i == HILO_OP_MFHI) begin
      rdata_o = hi_q;
    end else if (op_i == HILO_OP_MFLO) begin
      rdata_o = lo_q;
    end
  end

  assign stall_o      = stall;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;
  assign mul_signed_o = mul_sgn_q;
  assign div_a_o      = div_a_q;
  assign div_b_o      = div_b_q;
  assign div_signed_o = div_sgn_q;

endmodule

// File: tb/tb_m1_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m1_muldiv_ctrl
//   Directed bench for the HI/LO sequencer with behavioural multiplier and
//   divider slaves. Expected HI/LO pairs and MFHI/MFLO read data are queued
//   by the stimulus; a monitor pops them whenever HI/LO changes or a read op
//   is accepted.
// ---------------------------------------------------------------------------
module tb_m1_muldiv_ctrl;
  import m1_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic        sgn;
  logic [31:0] rs, rt;
  logic        stall_o;
  logic [31:0] rdata_o, hi_o, lo_o;
  logic [31:0] mul_a_o, mul_b_o, div_a_o, div_b_o;
  logic        mul_signed_o, div_signed_o, mul_req_o, div_req_o;
  logic        mul_ack, div_ack, mul_ack_dut, ack_flip;
  logic [63:0] mul_prod, mul_full, mul_pa, mul_pb;
  logic [31:0] div_quo, div_rem, div_q_full, div_r_full;
  int          mul_cnt, div_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] hl_q[$];
  logic [31:0] rd_q[$];
  logic [63:0] prev_hl = 64'd0;

  always #5 clk = ~clk;

  m1_muldiv_ctrl dut (
    .sys_clock_i     (clk),
    .sys_reset_i     (rst_n),
    .op_valid_i      (op_valid),
    .op_i            (op),
    .signed_i        (sgn),
    .rs_i            (rs),
    .rt_i            (rt),
    .stall_o         (stall_o),
    .rdata_o         (rdata_o),
    .hi_o            (hi_o),
    .lo_o            (lo_o),
    .mul_a_o         (mul_a_o),
    .mul_b_o         (mul_b_o),
    .mul_signed_o    (mul_signed_o),
    .mul_req_o       (mul_req_o),
    .mul_ack_i       (mul_ack_dut),
    .mul_product_i   (mul_prod),
    .div_a_o         (div_a_o),
    .div_b_o         (div_b_o),
    .div_signed_o    (div_signed_o),
    .div_req_o       (div_req_o),
    .div_ack_i       (div_ack),
    .div_quotient_i  (div_quo),
    .div_remainder_i (div_rem)
  );

  // Behavioural multiplier: answers four cycles after a new request level.
  assign mul_pa      = mul_signed_o ? {{32{mul_a_o[31]}}, mul_a_o} : {32'd0, mul_a_o};
  assign mul_pb      = mul_signed_o ? {{32{mul_b_o[31]}}, mul_b_o} : {32'd0, mul_b_o};
  assign mul_full    = mul_pa * mul_pb;
  assign mul_ack_dut = mul_ack ^ ack_flip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ack <= 1'b0; mul_cnt <= 0; mul_prod <= 64'd0;
    end else if (mul_req_o != mul_ack) begin
      if (mul_cnt == 3) begin
        mul_ack <= mul_req_o; mul_cnt <= 0; mul_prod <= mul_full;
      end else mul_cnt <= mul_cnt + 1;
    end
  end

  // Behavioural divider: answers five cycles after a new request level.
  always_comb begin
    div_q_full = 32'd0;
    div_r_full = 32'd0;
    if (div_b_o != 32'd0) begin
      if (div_signed_o) begin
        div_q_full = $signed(div_a_o) / $signed(div_b_o);
        div_r_full = $signed(div_a_o) % $signed(div_b_o);
      end else begin
        div_q_full = div_a_o / div_b_o;
        div_r_full = div_a_o % div_b_o;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ack <= 1'b0; div_cnt <= 0; div_quo <= 32'd0; div_rem <= 32'd0;
    end else if (div_req_o != div_ack) begin
      if (div_cnt == 4) begin
        div_ack <= div_req_o; div_cnt <= 0; div_quo <= div_q_full; div_rem <= div_r_full;
      end else div_cnt <= div_cnt + 1;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every HI/LO change and every accepted MFHI/MFLO is checked
  // against the next queued expectation.
  always @(negedge clk) begin
    if ({hi_o, lo_o} !== prev_hl) begin
      if (hl_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL hilo_unexpected: got %h expected unchanged %h", {hi_o, lo_o}, prev_hl);
      end else begin
        chk("hilo_update", {hi_o, lo_o}, hl_q.pop_front());
      end
      prev_hl = {hi_o, lo_o};
    end
    if (rst_n && op_valid && !stall_o && (op == HILO_OP_MFHI || op == HILO_OP_MFLO)) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL rdata_unexpected: got %h expected no read", rdata_o);
      end else begin
        chk("rdata", {32'd0, rdata_o}, {32'd0, rd_q.pop_front()});
      end
    end
  end

  task automatic drive(logic [2:0] o, logic s, logic [31:0] a, logic [31:0] b);
    op_valid = 1'b1; op = o; sgn = s; rs = a; rt = b;
  endtask

  // Waits for the held op to be accepted, then returns 1 ns after that edge.
  task automatic wait_accept(string name);
    int n = 0;
    @(negedge clk);
    while (stall_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got stall after %0d cycles expected accept", name, n);
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op = HILO_OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; op_valid = 1'b0; op = HILO_OP_NONE; sgn = 1'b0;
    rs = 32'd0; rt = 32'd0; ack_flip = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Reset state and reads
    chk("rst_stall", stall_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_reqs", {mul_req_o, div_req_o}, 0);
    @(posedge clk); #1;
    rd_q.push_back(32'd0); drive(HILO_OP_MFHI, 0, 0, 0); wait_accept("mfhi0");
    rd_q.push_back(32'd0); drive(HILO_OP_MFLO, 0, 0, 0); wait_accept("mflo0");

    // Unsigned 17*3 with a stalled MFLO behind it
    hl_q.push_back({32'd0, 32'd51});
    drive(HILO_OP_MULT, 0, 32'd17, 32'd3); wait_accept("mult_u");
    chk("mul_req_toggle", mul_req_o, 1);
    chk("mul_ops", {mul_a_o, mul_b_o}, {32'd17, 32'd3});
    rd_q.push_back(32'd51); drive(HILO_OP_MFLO, 0, 0, 0);
    @(negedge clk);
    chk("mflo_stall_busy", stall_o, 1);
    n = 0;
    while (mul_ack_dut !== mul_req_o && n < 50) begin @(negedge clk); n++; end
    chk("mul_ack_arrives", n < 50, 1);
    chk("stall_on_done_cycle", stall_o, 1);
    chk("lo_not_yet", lo_o, 0);
    @(negedge clk);
    chk("lo_after_done", lo_o, 51);
    chk("stall_released", stall_o, 0);
    @(posedge clk); #1; op_valid = 1'b0; op = HILO_OP_NONE;

    // Signed -7*3
    hl_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    drive(HILO_OP_MULT, 1, 32'hFFFF_FFF9, 32'd3); wait_accept("mult_s");
    chk("mul_signed", mul_signed_o, 1);
    rd_q.push_back(32'hFFFF_FFFF); drive(HILO_OP_MFHI, 0, 0, 0); wait_accept("mfhi_s");
    rd_q.push_back(32'hFFFF_FFEB); drive(HILO_OP_MFLO, 0, 0, 0); wait_accept("mflo_s");

    // Unsigned 17/5
    hl_q.push_back({32'd2, 32'd3});
    drive(HILO_OP_DIV, 0, 32'd17, 32'd5); wait_accept("div_u");
    chk("div_req_toggle", div_req_o, 1);
    rd_q.push_back(32'd3); drive(HILO_OP_MFLO, 0, 0, 0); wait_accept("mflo_d");
    rd_q.push_back(32'd2); drive(HILO_OP_MFHI, 0, 0, 0); wait_accept("mfhi_d");

    // Divide by zero: no request, fixed result one cycle after acceptance
    hl_q.push_back({32'd9, 32'hFFFF_FFFF});
    drive(HILO_OP_DIV, 0, 32'd9, 32'd0); wait_accept("div_z");
    rd_q.push_back(32'd9); drive(HILO_OP_MFHI, 0, 0, 0);
    @(negedge clk);
    chk("divz_no_req", div_req_o, 1);
    chk("divz_stall", stall_o, 1);
    chk("divz_hi_pending", hi_o, 2);
    @(negedge clk);
    chk("divz_hi", hi_o, 9);
    chk("divz_lo", lo_o, 32'hFFFF_FFFF);
    @(posedge clk); #1; op_valid = 1'b0; op = HILO_OP_NONE;

    // MTHI in IDLE
    hl_q.push_back({32'h1234, 32'hFFFF_FFFF});
    drive(HILO_OP_MTHI, 0, 32'h1234, 0); wait_accept("mthi");
    chk("mthi_next_cycle", hi_o, 32'h1234);

    // MTLO held behind a DIV 100/7
    hl_q.push_back({32'd2, 32'd14});
    hl_q.push_back({32'd2, 32'hABCD});
    drive(HILO_OP_DIV, 0, 32'd100, 32'd7); wait_accept("div_mtlo");
    drive(HILO_OP_MTLO, 0, 32'hABCD, 0);
    @(negedge clk);
    chk("mtlo_stall", stall_o, 1);
    wait_accept("mtlo");
    chk("mtlo_applied", {hi_o, lo_o}, {32'd2, 32'hABCD});

    // Stray ack level while idle must be ignored
    ack_flip = 1'b1;
    rd_q.push_back(32'd2); drive(HILO_OP_MFHI, 0, 0, 0); wait_accept("mfhi_err");
    repeat (3) @(posedge clk);
    #1;
    chk("proto_err_hilo", {hi_o, lo_o}, {32'd2, 32'hABCD});
    ack_flip = 1'b0;

    // Reset in the middle of a multiply
    drive(HILO_OP_MULT, 0, 32'd5, 32'd6); wait_accept("mult_rst");
    @(posedge clk); #2;
    hl_q.push_back(64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mul_req_o, 0);
    chk("rst_mid_hilo", {hi_o, lo_o}, 0);
    chk("rst_mid_stall", stall_o, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    hl_q.push_back({32'd0, 32'd4});
    drive(HILO_OP_MULT, 0, 32'd2, 32'd2); wait_accept("mult_after_rst");
    rd_q.push_back(32'd4); drive(HILO_OP_MFLO, 0, 0, 0); wait_accept("mflo_after_rst");

    repeat (5) @(negedge clk);
    chk("hl_queue_drained", hl_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
